// File: rtl/mem_arbiter.sv
// Arbiter for a processor and a loader/DMA requester sharing one single-port synchronous memory.
// Define MEM_ARB_STATS_EN to enable the 16-bit saturating conflict-cycle counter on 'conflicts'.
module mem_arbiter #(
    parameter int NBITS = 8,
    parameter int BURST = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p_req,
    input  logic             p_we,
    input  logic [NBITS-3:0] p_addr,
    input  logic [NBITS-1:0] p_wdata,
    output logic             p_gnt,
    output logic             p_rvalid,
    output logic [NBITS-1:0] p_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [NBITS-3:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [NBITS-1:0] d_rdata,
    output logic [NBITS-3:0] mem_address,
    output logic [NBITS-1:0] mem_data,
    output logic             mem_wren,
    input  logic [NBITS-1:0] mem_q,
    output logic [15:0]      conflicts
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, P_OWN, D_OWN} state_t;
    typedef enum logic {OWNER_P, OWNER_D} owner_t;

    state_t        state, state_next;
    owner_t        last_owner, last_owner_next;
    logic [CW-1:0] burst_cnt, burst_next;
    logic          at_limit;

    assign at_limit = (burst_cnt == CW'(BURST));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= OWNER_D;
            p_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_next;
            last_owner <= last_owner_next;
            p_rvalid   <= p_gnt & ~p_we;
            d_rvalid   <= d_gnt & ~d_we;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        p_gnt           = 1'b0;
        d_gnt           = 1'b0;
        state_next      = IDLE;
        burst_next      = '0;
        last_owner_next = last_owner;

        // Grants are gated by reset so a held reset can never reach the memory.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (p_req && d_req) begin
                        p_gnt = (last_owner == OWNER_D);
                        d_gnt = (last_owner == OWNER_P);
                    end else begin
                        p_gnt = p_req;
                        d_gnt = d_req;
                    end
                end
                P_OWN: begin
                    if (p_req && !(at_limit && d_req)) p_gnt = 1'b1;
                    else                               d_gnt = d_req;
                end
                D_OWN: begin
                    if (d_req && !(at_limit && p_req)) d_gnt = 1'b1;
                    else                               p_gnt = p_req;
                end
                default: ;
            endcase
        end

        if (p_gnt) begin
            state_next      = P_OWN;
            last_owner_next = OWNER_P;
            if (state == P_OWN) burst_next = at_limit ? burst_cnt : burst_cnt + 1'b1;
            else                burst_next = CW'(1);
        end else if (d_gnt) begin
            state_next      = D_OWN;
            last_owner_next = OWNER_D;
            if (state == D_OWN) burst_next = at_limit ? burst_cnt : burst_cnt + 1'b1;
            else                burst_next = CW'(1);
        end
    end

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (p_gnt) begin
            mem_address = p_addr;
            mem_data    = p_wdata;
            mem_wren    = p_we;
        end else if (d_gnt) begin
            mem_address = d_addr;
            mem_data    = d_wdata;
            mem_wren    = d_we;
        end
    end

    assign p_rdata = mem_q;
    assign d_rdata = mem_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            conflict_cnt <= '0;
        else if (p_req && d_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign conflicts = conflict_cnt;
`else
    assign conflicts = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory; stimulus pushes expected grants
// and read returns into queues and a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int NB = 8;
    localparam int AW = NB - 2;
    localparam int GN = 0;
    localparam int GP = 1;
    localparam int GD = 2;

    logic          clock, reset;
    logic          p_req, p_we, d_req, d_we;
    logic [AW-1:0] p_addr, d_addr;
    logic [NB-1:0] p_wdata, d_wdata;
    logic          p_gnt, p_rvalid, d_gnt, d_rvalid;
    logic [NB-1:0] p_rdata, d_rdata;
    logic [AW-1:0] mem_address;
    logic [NB-1:0] mem_data, mem_q;
    logic          mem_wren;
    logic [15:0]   conflicts;

    mem_arbiter #(.NBITS(NB), .BURST(4)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .conflicts(conflicts)
    );

    typedef struct {
        int            cyc;
        logic [1:0]    who;
        logic          wren;
        logic [AW-1:0] addr;
        logic [NB-1:0] data;
    } gnt_exp_t;

    typedef struct {
        int            cyc;
        logic [NB-1:0] data;
    } rd_exp_t;

    gnt_exp_t gq[$];
    rd_exp_t  prq[$];
    rd_exp_t  drq[$];

    logic [NB-1:0] mem     [2**AW];
    logic [NB-1:0] mem_ref [2**AW];

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_conf = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Applies one cycle of inputs and records the hand-determined grant g for that cycle.
    task automatic drive(input logic rst,
                         input logic pr, input logic pw, input logic [AW-1:0] pa, input logic [NB-1:0] pd,
                         input logic dr, input logic dw, input logic [AW-1:0] da, input logic [NB-1:0] dd,
                         input int g, input bit rv_kept = 1'b1);
        gnt_exp_t ge;
        rd_exp_t  re;
        reset = rst;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        if (g == GP) begin
            ge.cyc = cyc; ge.who = 2'b01; ge.wren = pw; ge.addr = pa; ge.data = pd;
            gq.push_back(ge);
            if (!pw && rv_kept) begin
                re.cyc = cyc + 1; re.data = mem_ref[pa];
                prq.push_back(re);
            end
            if (pw) mem_ref[pa] = pd;
        end else if (g == GD) begin
            ge.cyc = cyc; ge.who = 2'b10; ge.wren = dw; ge.addr = da; ge.data = dd;
            gq.push_back(ge);
            if (!dw && rv_kept) begin
                re.cyc = cyc + 1; re.data = mem_ref[da];
                drq.push_back(re);
            end
            if (dw) mem_ref[da] = dd;
        end
        if (rst)           exp_conf = 0;
        else if (pr && dr) exp_conf++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, GN);
    endtask

    task automatic check_conflicts(input string name);
`ifdef MEM_ARB_STATS_EN
        check(name, conflicts, exp_conf);
`else
        check(name, conflicts, 0);
`endif
    endtask

    gnt_exp_t mg;
    rd_exp_t  mr;

    always @(negedge clock) begin
        check("single_grant", p_gnt & d_gnt, 1'b0);
        if (p_gnt || d_gnt) begin
            if (gq.size() == 0) begin
                check("gnt_spurious", {d_gnt, p_gnt}, 2'b00);
            end else begin
                mg = gq.pop_front();
                check("gnt_cycle", cyc, mg.cyc);
                check("gnt_who", {d_gnt, p_gnt}, mg.who);
                check("mem_address", mem_address, mg.addr);
                check("mem_data", mem_data, mg.data);
                check("mem_wren", mem_wren, mg.wren);
            end
        end else begin
            check("idle_address", mem_address, 0);
            check("idle_data", mem_data, 0);
            check("idle_wren", mem_wren, 0);
        end
        if (p_rvalid) begin
            if (prq.size() == 0) begin
                check("p_rvalid_spurious", p_rvalid, 1'b0);
            end else begin
                mr = prq.pop_front();
                check("p_rvalid_cycle", cyc, mr.cyc);
                check("p_rdata", p_rdata, mr.data);
            end
        end
        if (d_rvalid) begin
            if (drq.size() == 0) begin
                check("d_rvalid_spurious", d_rvalid, 1'b0);
            end else begin
                mr = drq.pop_front();
                check("d_rvalid_cycle", cyc, mr.cyc);
                check("d_rdata", d_rdata, mr.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            mem_ref[i] = 8'(i * 7 + 3);
        end
        mem[5]     = 8'hA3;
        mem_ref[5] = 8'hA3;

        // Reset held with both requesters asking to write: nothing may reach the memory.
        reset = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_addr = 6'h03; p_wdata = 8'hFF;
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'h04; d_wdata = 8'hEE;
        repeat (2) @(posedge clock);
        #1;
        check("rst_p_gnt", p_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_p_rvalid", p_rvalid, 1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_conflicts", conflicts, 16'h0000);

        // Processor read of word 5 (0xA3).
        drive(1'b0, 1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, GP);
        idle();

        // Lone DMA write 0x5C to 0x3F, then read it back.
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h3F, 8'h5C, GD);
        idle();
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h3F, 8'h00, GD);
        idle();

        // Continuous contention from IDLE with last owner D: P x4, D x4, P x2.
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00,
                  (i < 4 || i >= 8) ? GP : GD);
        check_conflicts("conflicts_after_contention");

        // P drops after two grants: D granted at once with a fresh burst of four.
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, GD);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, GD);
        drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, GP);

        // D alone for ten cycles: granted every cycle, burst count saturates.
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'(i), 8'h00, GD);

        // Saturated D burst yields to an arriving P write; D then reads the new value.
        drive(1'b0, 1'b1, 1'b1, 6'h10, 8'h77, 1'b1, 1'b0, 6'h10, 8'h00, GP);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h10, 8'h00, GD);
        idle();
        check_conflicts("conflicts_after_bursts");

        // Reset in the cycle after a granted P read kills its rvalid and restores P priority.
        drive(1'b0, 1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, GP, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, GN);
        check("midrst_p_rvalid", p_rvalid, 1'b0);
        check("midrst_conflicts", conflicts, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, GP);
        idle();
        idle();
        check_conflicts("conflicts_final");

        check("gnt_queue_left", gq.size(), 0);
        check("p_rd_queue_left", prq.size(), 0);
        check("d_rd_queue_left", drq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter NBITS, default 8, giving the data width; the word address width is NBITS-2.
REQ-002 The module SHALL have parameter BURST, default 4, giving the maximum consecutive grants to one requester while the other waits.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 p_req, p_we  input  1 each  processor access request and write enable.
REQ-006 p_addr  input  NBITS-2  processor word address; p_wdata  input  NBITS  processor write data.
REQ-007 p_gnt  output  1  processor access accepted this cycle.
REQ-008 p_rvalid  output  1  processor read data valid; p_rdata  output  NBITS  processor read data.
REQ-009 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata SHALL exist with the same directions, widths and meanings for the loader/DMA requester.
REQ-010 mem_address  output  NBITS-2, mem_data  output  NBITS, mem_wren  output  1  drive the single-port synchronous memory.
REQ-011 mem_q  input  NBITS  memory read data, valid one cycle after the address is sampled.
REQ-012 conflicts  output  16  count of cycles in which both requests were asserted.

Function
REQ-013 The arbiter SHALL have states IDLE, P_OWN and D_OWN, plus a burst counter (0..BURST) and a round-robin pointer last_owner.
REQ-014 Grants SHALL be combinational from the current state and requests: at most one of p_gnt/d_gnt is high, and never without its req.
REQ-015 In IDLE with exactly one req high, that requester SHALL be granted; with both high, the requester not equal to last_owner SHALL be granted.
REQ-016 In X_OWN with X requesting and burst count < BURST, X SHALL be granted.
REQ-017 In X_OWN with X requesting, count == BURST and the other requesting, the other SHALL be granted; if the other is idle, X SHALL continue to be granted and the count SHALL saturate at BURST.
REQ-018 In X_OWN with X not requesting, the other SHALL be granted if requesting; otherwise there is no grant.
REQ-019 Next state SHALL be the granted requester's OWN state, or IDLE if nothing is granted.
REQ-020 The burst count SHALL be set to 1 on an owner change and incremented on a repeat grant.
REQ-021 last_owner SHALL be updated to the granted requester on every grant.
REQ-022 mem_address and mem_data SHALL mux from the granted requester; mem_wren = grant AND that requester's we.
REQ-023 With no grant, mem_address SHALL be 0, mem_data 0 and mem_wren 0.
REQ-024 X_rvalid SHALL be registered high exactly one cycle after a granted read (we = 0) by X; writes SHALL never produce rvalid.
REQ-025 p_rdata and d_rdata SHALL both equal mem_q combinationally; they are meaningful only while the respective rvalid is high.
REQ-026 Back-to-back reads SHALL be supported at one per cycle: grant in cycle n, rvalid in cycle n+1, with a new grant possible in cycle n+1.
REQ-027 Requesters SHALL hold req, we, addr and wdata stable until gnt is sampled high; the arbiter does not buffer requests.

Reset
REQ-028 While reset is high, state SHALL be IDLE, burst count 0, last_owner = D (processor wins the first tie), p_rvalid = d_rvalid = 0 and conflicts = 0.
REQ-029 While reset is high, grants SHALL be forced to 0 and mem_wren to 0, regardless of requests.
REQ-030 Reset asserted mid-read SHALL suppress the pending rvalid; the first grant after release SHALL follow REQ-015.

Configuration
REQ-031 With macro MEM_ARB_STATS_EN defined, conflicts SHALL increment each cycle that p_req and d_req are both high, saturating at 16'hFFFF.
REQ-032 Without MEM_ARB_STATS_EN, conflicts SHALL be tied to 0, no counter register SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-033 After reset, p_req=1, we=0, addr=0x05 with mem[5]=0xA3 -> p_gnt=1 same cycle; next cycle p_rvalid=1, p_rdata=0xA3.
REQ-034 Both req from reset, continuous, BURST=4 -> grant order P,P,P,P,D,D,D,D,P...; conflicts = cycles elapsed when MEM_ARB_STATS_EN is defined.
REQ-035 d_req=1, d_we=1, addr=0x3F, wdata=0x5C alone -> d_gnt=1, mem_wren=1, mem_address=0x3F, mem_data=0x5C; no d_rvalid.
REQ-036 Owner P drops req after 2 grants while d_req=1 -> d_gnt in the same cycle as the drop; burst count = 1.
REQ-037 reset pulsed in the cycle after a granted P read -> p_rvalid stays 0; after release, tie -> P granted.
REQ-038 Only D requesting for 10 cycles -> d_gnt=1 every cycle with no forced gaps; the count saturates at 4.
